// File: rtl/if_cam_unpacker_if.sv
// Handshake bundle between the IF CAM, the row unpacker and its downstream consumer.
// The miss_cnt signal exists only when IF_UNPACK_MISS_CNT_EN is defined.
interface if_cam_unpacker_if #(
  parameter int APPEND_WIDTH = 81,
  parameter int APPEND_NUM   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int CNT_WIDTH    = 16
);
  localparam int IDX_W = $clog2(APPEND_NUM);

  logic                               row_vld_in;
  logic                               row_notfound_in;
  logic [DATA_WIDTH-1:0]              row_key_in;
  logic [APPEND_NUM*APPEND_WIDTH-1:0] row_data_in;
  logic [IDX_W-1:0]                   row_num_in;
  logic                               row_rdy_out;
  logic                               out_vld;
  logic                               out_rdy;
  logic [DATA_WIDTH-1:0]              out_key;
  logic [APPEND_WIDTH-1:0]            out_data;
  logic [IDX_W-1:0]                   out_idx;
  logic                               out_first;
  logic                               out_last;
  logic                               miss_pulse;
`ifdef IF_UNPACK_MISS_CNT_EN
  logic [CNT_WIDTH-1:0]               miss_cnt;
`endif

  // Environment side: drives the CAM row and the downstream ready.
  modport master (
    output row_vld_in, row_notfound_in, row_key_in, row_data_in, row_num_in, out_rdy,
    input  row_rdy_out, out_vld, out_key, out_data, out_idx, out_first, out_last, miss_pulse
`ifdef IF_UNPACK_MISS_CNT_EN
    , input miss_cnt
`endif
  );

  // Unpacker side.
  modport slave (
    input  row_vld_in, row_notfound_in, row_key_in, row_data_in, row_num_in, out_rdy,
    output row_rdy_out, out_vld, out_key, out_data, out_idx, out_first, out_last, miss_pulse
`ifdef IF_UNPACK_MISS_CNT_EN
    , output miss_cnt
`endif
  );
endinterface

// File: rtl/if_cam_unpacker.sv
// Buffers CAM search-result rows in a small FIFO and serialises each row into one beat per entry.
// Optional saturating miss counter enabled by defining IF_UNPACK_MISS_CNT_EN.
module if_cam_unpacker #(
  parameter int APPEND_WIDTH = 81,
  parameter int APPEND_NUM   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int ROW_DEPTH    = 2,
  parameter int CNT_WIDTH    = 16
) (
  input logic               clk,
  input logic               rst_n,
  if_cam_unpacker_if.slave  bus
);
  localparam int IDX_W = $clog2(APPEND_NUM);
  localparam int PTR_W = $clog2(ROW_DEPTH);
  localparam int ROW_W = APPEND_NUM * APPEND_WIDTH;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(ROW_DEPTH);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   key_mem  [ROW_DEPTH];
  logic [ROW_W-1:0]        data_mem [ROW_DEPTH];
  logic [IDX_W-1:0]        num_mem  [ROW_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [PTR_W:0]          fifo_count;
  logic [IDX_W-1:0]        rd_idx;
  logic                    fifo_empty, row_rdy, push, miss;
  logic                    load, take, pop, is_last;
  logic [APPEND_WIDTH-1:0] head_entry;
  logic [DATA_WIDTH-1:0]   out_key_q;
  logic [APPEND_WIDTH-1:0] out_data_q;
  logic [IDX_W-1:0]        out_idx_q;
  logic                    out_first_q, out_last_q, miss_pulse_q;

  // Space is judged from the registered count alone, so a pop this cycle frees a slot only next cycle.
  assign row_rdy    = (fifo_count < DEPTH_C);
  assign fifo_empty = (fifo_count == '0);
  assign push       = bus.row_vld_in && row_rdy;
  // A row and a miss on the same cycle is a row; the miss is dropped.
  assign miss       = bus.row_notfound_in && !bus.row_vld_in && row_rdy;
  assign is_last    = (rd_idx == num_mem[rd_ptr]);
  assign head_entry = data_mem[rd_ptr][rd_idx*APPEND_WIDTH +: APPEND_WIDTH];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    load       = (state == IDLE) || bus.out_rdy;
    take       = 1'b0;
    pop        = 1'b0;
    state_next = state;
    if (load) begin
      take       = !fifo_empty;
      pop        = !fifo_empty && is_last;
      state_next = fifo_empty ? IDLE : EMIT;
    end
  end

  // NOTE: row storage has no reset; the count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      key_mem[wr_ptr]  <= bus.row_key_in;
      data_mem[wr_ptr] <= bus.row_data_in;
      num_mem[wr_ptr]  <= bus.row_num_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      rd_idx       <= '0;
      out_key_q    <= '0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
      miss_pulse_q <= 1'b0;
    end else begin
      state        <= state_next;
      miss_pulse_q <= miss;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
      if (take) begin
        out_key_q   <= key_mem[rd_ptr];
        out_data_q  <= head_entry;
        out_idx_q   <= rd_idx;
        out_first_q <= (rd_idx == '0);
        out_last_q  <= is_last;
        rd_idx      <= is_last ? '0 : rd_idx + 1'b1;
      end
    end
  end

`ifdef IF_UNPACK_MISS_CNT_EN
  logic [CNT_WIDTH-1:0] miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            miss_cnt_q <= '0;
    else if (miss_pulse_q && ~&miss_cnt_q) miss_cnt_q <= miss_cnt_q + 1'b1;
  end

  assign bus.miss_cnt = miss_cnt_q;
`endif

  assign bus.row_rdy_out = row_rdy;
  assign bus.out_vld     = (state == EMIT);
  assign bus.out_key     = out_key_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_idx     = out_idx_q;
  assign bus.out_first   = out_first_q;
  assign bus.out_last    = out_last_q;
  assign bus.miss_pulse  = miss_pulse_q;
endmodule

// File: tb/tb_if_cam_unpacker.sv
// Directed bench for if_cam_unpacker: row serialisation, back-pressure, misses and mid-row reset.
// With IF_UNPACK_MISS_CNT_EN defined it also checks the miss counter, including a 2-bit saturating copy.
module tb_if_cam_unpacker;
  localparam int AW    = 81;
  localparam int AN    = 8;
  localparam int DW    = 32;
  localparam int ROW_W = AW * AN;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  if_cam_unpacker_if #(.APPEND_WIDTH(AW), .APPEND_NUM(AN), .DATA_WIDTH(DW)) bus ();
  if_cam_unpacker #(.APPEND_WIDTH(AW), .APPEND_NUM(AN), .DATA_WIDTH(DW), .ROW_DEPTH(2))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

`ifdef IF_UNPACK_MISS_CNT_EN
  if_cam_unpacker_if #(.APPEND_WIDTH(AW), .APPEND_NUM(AN), .DATA_WIDTH(DW), .CNT_WIDTH(2)) sat_bus ();
  if_cam_unpacker #(.APPEND_WIDTH(AW), .APPEND_NUM(AN), .DATA_WIDTH(DW), .ROW_DEPTH(2), .CNT_WIDTH(2))
    dut_sat (.clk(clk), .rst_n(rst_n), .bus(sat_bus.slave));
  assign sat_bus.row_vld_in      = bus.row_vld_in;
  assign sat_bus.row_notfound_in = bus.row_notfound_in;
  assign sat_bus.row_key_in      = bus.row_key_in;
  assign sat_bus.row_data_in     = bus.row_data_in;
  assign sat_bus.row_num_in      = bus.row_num_in;
  assign sat_bus.out_rdy         = bus.out_rdy;
`endif

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] mk_entry(input logic [7:0] base, input int i);
    return AW'({base, 8'(i)});
  endfunction

  // Entries above row_num carry the same pattern, so an over-run shows up as a wrong beat.
  function automatic logic [ROW_W-1:0] mk_row(input logic [7:0] base);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < AN; i++) r[i*AW +: AW] = mk_entry(base, i);
    return r;
  endfunction

  task automatic drive_row(input logic [7:0] base, input logic [2:0] num);
    bus.row_vld_in  = 1'b1;
    bus.row_key_in  = DW'(base);
    bus.row_data_in = mk_row(base);
    bus.row_num_in  = num;
  endtask

  initial begin
    logic [ROW_W-1:0] row_abc;
    logic [AW-1:0]    ent_a, ent_b, ent_c;
    int               idx;
    logic [7:0]       base;

    rst_n               = 1'b0;
    bus.row_vld_in      = 1'b0;
    bus.row_notfound_in = 1'b0;
    bus.row_key_in      = '0;
    bus.row_data_in     = '0;
    bus.row_num_in      = '0;
    bus.out_rdy         = 1'b0;

    // Reset state
    #12;
    check("rst_row_rdy", 128'(bus.row_rdy_out), 128'(1));
    check("rst_out_vld", 128'(bus.out_vld), 128'(0));
    check("rst_miss_pulse", 128'(bus.miss_pulse), 128'(0));
    check("rst_out_data", 128'(bus.out_data), 128'(0));
    check("rst_out_idx", 128'(bus.out_idx), 128'(0));
`ifdef IF_UNPACK_MISS_CNT_EN
    check("rst_miss_cnt", 128'(bus.miss_cnt), 128'(0));
`endif
    step();
    rst_n = 1'b1;
    step();

    // Three-entry row: entries A,B,C, junk above row_num
    ent_a   = 81'h1_AAAA_AAAA_AAAA_AAAA_AAAA;
    ent_b   = 81'h0_BBBB_BBBB_BBBB_BBBB_BBBB;
    ent_c   = 81'h1_CCCC_CCCC_CCCC_CCCC_CCCC;
    row_abc = '1;
    row_abc[0*AW +: AW] = ent_a;
    row_abc[1*AW +: AW] = ent_b;
    row_abc[2*AW +: AW] = ent_c;
    bus.out_rdy     = 1'b1;
    bus.row_vld_in  = 1'b1;
    bus.row_key_in  = 32'h1234;
    bus.row_data_in = row_abc;
    bus.row_num_in  = 3'd2;
    step();
    bus.row_vld_in = 1'b0;
    step();
    check("t2_b0_vld", 128'(bus.out_vld), 128'(1));
    check("t2_b0_key", 128'(bus.out_key), 128'(32'h1234));
    check("t2_b0_data", 128'(bus.out_data), 128'(ent_a));
    check("t2_b0_flags", 128'({bus.out_idx, bus.out_first, bus.out_last}), 128'({3'd0, 1'b1, 1'b0}));
    step();
    check("t2_b1_data", 128'(bus.out_data), 128'(ent_b));
    check("t2_b1_flags", 128'({bus.out_vld, bus.out_idx, bus.out_first, bus.out_last}), 128'({1'b1, 3'd1, 1'b0, 1'b0}));
    step();
    check("t2_b2_data", 128'(bus.out_data), 128'(ent_c));
    check("t2_b2_flags", 128'({bus.out_vld, bus.out_idx, bus.out_first, bus.out_last}), 128'({1'b1, 3'd2, 1'b0, 1'b1}));
    step();
    check("t2_idle", 128'(bus.out_vld), 128'(0));

    // Back-to-back rows num=0 then num=1: three beats with no gap
    drive_row(8'h0A, 3'd0);
    step();
    drive_row(8'h0B, 3'd1);
    step();
    bus.row_vld_in = 1'b0;
    check("t3_b0", 128'({bus.out_vld, bus.out_key[7:0], bus.out_idx, bus.out_first, bus.out_last}), 128'({1'b1, 8'h0A, 3'd0, 1'b1, 1'b1}));
    check("t3_b0_data", 128'(bus.out_data), 128'(mk_entry(8'h0A, 0)));
    step();
    check("t3_b1", 128'({bus.out_vld, bus.out_key[7:0], bus.out_idx, bus.out_first, bus.out_last}), 128'({1'b1, 8'h0B, 3'd0, 1'b1, 1'b0}));
    step();
    check("t3_b2", 128'({bus.out_vld, bus.out_key[7:0], bus.out_idx, bus.out_first, bus.out_last}), 128'({1'b1, 8'h0B, 3'd1, 1'b0, 1'b1}));
    check("t3_b2_data", 128'(bus.out_data), 128'(mk_entry(8'h0B, 1)));
    step();
    check("t3_idle", 128'(bus.out_vld), 128'(0));

    // Back-pressure: two num=3 rows fill the FIFO, third is refused, output holds
    bus.out_rdy = 1'b0;
    drive_row(8'h11, 3'd3);
    step();
    check("t4_rdy_after_1", 128'(bus.row_rdy_out), 128'(1));
    drive_row(8'h22, 3'd3);
    step();
    drive_row(8'h33, 3'd3);
    check("t4_rdy_full", 128'(bus.row_rdy_out), 128'(0));
    for (int c = 0; c < 3; c++) step();
    check("t4_still_full", 128'(bus.row_rdy_out), 128'(0));
    check("t4_hold", 128'({bus.out_vld, bus.out_key[7:0], bus.out_idx, bus.out_first, bus.out_last}), 128'({1'b1, 8'h11, 3'd0, 1'b1, 1'b0}));
    check("t4_hold_data", 128'(bus.out_data), 128'(mk_entry(8'h11, 0)));
    bus.row_vld_in = 1'b0;
    bus.out_rdy    = 1'b1;
    for (int b = 0; b < 8; b++) begin
      idx  = b % 4;
      base = (b < 4) ? 8'h11 : 8'h22;
      check($sformatf("t4_beat%0d", b),
            128'({bus.out_vld, bus.out_key[7:0], bus.out_idx, bus.out_first, bus.out_last}),
            128'({1'b1, base, 3'(idx), idx == 0, idx == 3}));
      check($sformatf("t4_data%0d", b), 128'(bus.out_data), 128'(mk_entry(base, idx)));
      step();
    end
    check("t4_idle", 128'(bus.out_vld), 128'(0));
    check("t4_rdy_drained", 128'(bus.row_rdy_out), 128'(1));

    // Five misses, then row+notfound together (row wins, no pulse)
    bus.row_notfound_in = 1'b1;
    for (int m = 0; m < 5; m++) begin
      step();
      check($sformatf("t5_pulse%0d", m), 128'(bus.miss_pulse), 128'(1));
    end
    bus.row_notfound_in = 1'b0;
    step();
    check("t5_pulse_end", 128'(bus.miss_pulse), 128'(0));
    check("t5_no_push", 128'(bus.out_vld), 128'(0));
`ifdef IF_UNPACK_MISS_CNT_EN
    check("t5_miss_cnt", 128'(bus.miss_cnt), 128'(5));
    check("t5_miss_cnt_sat", 128'(sat_bus.miss_cnt), 128'(3));
`endif
    drive_row(8'h77, 3'd0);
    bus.row_notfound_in = 1'b1;
    step();
    bus.row_vld_in      = 1'b0;
    bus.row_notfound_in = 1'b0;
    check("t5_both_no_pulse", 128'(bus.miss_pulse), 128'(0));
    step();
    check("t5_both_pushed", 128'({bus.out_vld, bus.out_key[7:0], bus.out_first, bus.out_last}), 128'({1'b1, 8'h77, 1'b1, 1'b1}));
    step();
    check("t5_both_idle", 128'(bus.out_vld), 128'(0));

    // Reset during idx1 of a num=3 row with a second row buffered
    drive_row(8'h55, 3'd3);
    step();
    drive_row(8'h66, 3'd3);
    step();
    bus.row_vld_in = 1'b0;
    step();
    check("t6_mid_row", 128'({bus.out_vld, bus.out_key[7:0], bus.out_idx}), 128'({1'b1, 8'h55, 3'd1}));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_vld", 128'(bus.out_vld), 128'(0));
    check("t6_rst_rdy", 128'(bus.row_rdy_out), 128'(1));
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("t6_no_stale%0d", c), 128'(bus.out_vld), 128'(0));
    end
    check("t6_rdy_after", 128'(bus.row_rdy_out), 128'(1));
    check("t6_idx_after", 128'(bus.out_idx), 128'(0));
`ifdef IF_UNPACK_MISS_CNT_EN
    check("t6_miss_cnt_cleared", 128'(bus.miss_cnt), 128'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
